lane_serializer: RTL



---
 rtl/lane_serializer_pkg.sv | 19 +
 rtl/lane_serializer_piso8.sv | 31 +++
 rtl/lane_serializer.sv | 112 +++++++++++
 3 files changed

// File: rtl/lane_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lane_serializer_pkg
// Purpose  : Shared lane symbols and serializer FSM encodings, also used by the
//            receive-side aligner.
// Revision : 1.0 - initial release
// ============================================================================
package lane_serializer_pkg;

  localparam logic [7:0] C_COM_SYMBOL = 8'hBC;
  localparam logic [7:0] C_SKP_SYMBOL = 8'h1C;

  typedef enum logic {
    SYNC = 1'b0,
    DATA = 1'b1
  } state_t;

endpackage : lane_serializer_pkg
`default_nettype wire

// File: rtl/lane_serializer_piso8.sv
`default_nettype none
// ============================================================================
// Module   : lane_serializer_piso8
// Purpose  : 8-bit parallel-load, MSB-first shift register with async
//            active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module lane_serializer_piso8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] d,
  output logic       q
);

  logic [7:0] r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (load) begin
      r_shift <= d;
    end else begin
      r_shift <= {r_shift[6:0], 1'b0};
    end
  end

  assign q = r_shift[7];

endmodule : lane_serializer_piso8
`default_nettype wire

// File: rtl/lane_serializer.sv
`default_nettype none
// ============================================================================
// Module   : lane_serializer
// Purpose  : Per-lane byte-to-bit serializer with COM training burst, COM idle
//            fill and optional SKP insertion (enabled by macro LANE_SKP_EN).
// Revision : 1.0 - initial release
// ============================================================================
module lane_serializer
  import lane_serializer_pkg::*;
#(
  parameter int unsigned SYNC_COUNT   = 4,
  parameter logic [7:0]  COM_SYMBOL   = C_COM_SYMBOL
`ifdef LANE_SKP_EN
  ,
  parameter logic [7:0]  SKP_SYMBOL   = C_SKP_SYMBOL,
  parameter int unsigned SKP_INTERVAL = 16
`endif
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       data_out,
  output logic       load_out,
  output logic       ready_out
);

  localparam int SC_W = $clog2(SYNC_COUNT + 1);

  logic [2:0]      r_bit_cnt;
  logic [SC_W-1:0] r_sync_cnt;
  state_t          r_state;
  logic            r_ready;
  logic            w_load;
  logic [7:0]      w_symbol;

  assign w_load = (r_bit_cnt == 3'd7);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_bit_cnt <= '0;
    end else begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

`ifdef LANE_SKP_EN
  localparam int IDLE_W = $clog2(SKP_INTERVAL);

  logic [IDLE_W-1:0] r_idle_cnt;
  logic              w_skp_due;

  assign w_skp_due = (r_idle_cnt == IDLE_W'(SKP_INTERVAL - 1));

  // Counts consecutive idle slots in DATA; a data slot or a SKP slot restarts it.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_idle_cnt <= '0;
    end else if (w_load && (r_state == DATA)) begin
      if (valid_in || w_skp_due) begin
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    w_symbol = COM_SYMBOL;
    if (r_state == DATA) begin
      if (valid_in) begin
        w_symbol = data_in;
      end
`ifdef LANE_SKP_EN
      else if (w_skp_due) begin
        w_symbol = SKP_SYMBOL;
      end
`endif
    end
  end

  // Training FSM: the load that completes the COM burst also raises ready.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_state    <= SYNC;
      r_sync_cnt <= '0;
      r_ready    <= 1'b0;
    end else if (w_load && (r_state == SYNC)) begin
      if (r_sync_cnt != SC_W'(SYNC_COUNT)) begin
        r_sync_cnt <= r_sync_cnt + 1'b1;
      end
      if (r_sync_cnt == SC_W'(SYNC_COUNT - 1)) begin
        r_state <= DATA;
        r_ready <= 1'b1;
      end
    end
  end

  lane_serializer_piso8 u_piso8 (
    .clk   (clk_32f),
    .rst_n (reset),
    .load  (w_load),
    .d     (w_symbol),
    .q     (data_out)
  );

  assign load_out  = w_load;
  assign ready_out = r_ready;

endmodule : lane_serializer
`default_nettype wire
